sync_debounce: RTL and testbench

//  Multi-channel input conditioner for asynchronous board inputs (switches, keys, GPIO).

---
 rtl/sync_debounce.sv | 69 ++++++
 tb/tb_sync_debounce.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - multi-channel synchronizer and debounce filter with edge pulses
module sync_debounce #(
    parameter int WIDTH    = 4,
    parameter int STAGES   = 2,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] sync_out,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int              CNT_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] stage [STAGES];
    logic [CNT_W-1:0] cnt   [WIDTH];

    // Metastability chain: each channel is shifted through STAGES flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < STAGES; k++) begin
                stage[k] <= '0;
            end
        end else begin
            stage[0] <= in;
            for (int k = 1; k < STAGES; k++) begin
                stage[k] <= stage[k-1];
            end
        end
    end

    assign sync_out = stage[STAGES-1];

    // Per-channel filter: a new level is accepted only after DEBOUNCE consecutive
    // mismatching cycles; any return to the current level discards the partial count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out  <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_out[i] == out[i]) begin
                    cnt[i]  <= '0;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end else if (cnt[i] == CNT_MAX) begin
                    out[i]  <= sync_out[i];
                    cnt[i]  <= '0;
                    rise[i] <= sync_out[i];
                    fall[i] <= ~sync_out[i];
                end else begin
                    cnt[i]  <= cnt[i] + CNT_ONE;
                    rise[i] <= 1'b0;
                    fall[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sync_debounce.sv
// tb/tb_sync_debounce.sv - scoreboard bench for sync_debounce (2/4 and 3/1 configurations)
module tb_sync_debounce;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in;

    logic [W-1:0] sync_a, out_a, rise_a, fall_a;
    logic [W-1:0] sync_b, out_b, rise_b, fall_b;

    always #5 clk = ~clk;

    sync_debounce #(.WIDTH(W), .STAGES(2), .DEBOUNCE(4)) u_dut_a (
        .clk(clk), .reset(reset), .in(in),
        .sync_out(sync_a), .out(out_a), .rise(rise_a), .fall(fall_a)
    );

    sync_debounce #(.WIDTH(W), .STAGES(3), .DEBOUNCE(1)) u_dut_b (
        .clk(clk), .reset(reset), .in(in),
        .sync_out(sync_b), .out(out_b), .rise(rise_b), .fall(fall_b)
    );

    typedef struct packed {
        logic [1:0][W-1:0] s;
        logic [1:0][W-1:0] o;
        logic [1:0][W-1:0] r;
        logic [1:0][W-1:0] f;
    } exp_t;

    exp_t exp_q [$];

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state, index 0 = dut_a, 1 = dut_b.
    int           stg [2] = '{2, 3};
    int           deb [2] = '{4, 1};
    logic [W-1:0] pipe  [2][8];   // pipe[d][k]: input value sampled k+1 edges ago
    logic [W-1:0] shist [2][8];   // shist[d][k]: synchronized level seen k edges ago
    logic [W-1:0] mout  [2];

    // One clock edge of the rules: sync_out is the input STAGES edges old; out flips once
    // the last DEBOUNCE synchronized samples all disagree with it.
    function automatic exp_t model_step(logic rst_n, logic [W-1:0] din);
        exp_t e;
        e = '0;
        for (int d = 0; d < 2; d++) begin
            logic [W-1:0] cur;
            if (!rst_n) begin
                for (int k = 0; k < 8; k++) begin
                    pipe[d][k]  = '0;
                    shist[d][k] = '0;
                end
                mout[d] = '0;
            end else begin
                cur = pipe[d][stg[d]-1];
                for (int k = 7; k > 0; k--) shist[d][k] = shist[d][k-1];
                shist[d][0] = cur;
                for (int i = 0; i < W; i++) begin
                    bit accept;
                    accept = 1'b1;
                    for (int k = 0; k < deb[d]; k++) begin
                        if (shist[d][k][i] == mout[d][i]) accept = 1'b0;
                    end
                    if (accept) begin
                        mout[d][i] = ~mout[d][i];
                        if (mout[d][i]) e.r[d][i] = 1'b1;
                        else            e.f[d][i] = 1'b1;
                        for (int k = 0; k < 8; k++) shist[d][k][i] = mout[d][i];
                    end
                end
                for (int k = 7; k > 0; k--) pipe[d][k] = pipe[d][k-1];
                pipe[d][0] = din;
            end
            e.s[d] = pipe[d][stg[d]-1];
            e.o[d] = mout[d];
        end
        return e;
    endfunction

    task automatic drive(input logic rst_n, input logic [W-1:0] din);
        reset = rst_n;
        in    = din;
        exp_q.push_back(model_step(rst_n, din));
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: after every edge compare DUT outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                if (vectors > 0) begin
                    miscompares++;
                    $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("a_sync", sync_a, e.s[0]);
                chk("a_out",  out_a,  e.o[0]);
                chk("a_rise", rise_a, e.r[0]);
                chk("a_fall", fall_a, e.f[0]);
                chk("b_sync", sync_b, e.s[1]);
                chk("b_out",  out_b,  e.o[1]);
                chk("b_rise", rise_b, e.r[1]);
                chk("b_fall", fall_b, e.f[1]);
                chk("a_rise_and_fall", rise_a & fall_a, '0);
                chk("b_rise_and_fall", rise_b & fall_b, '0);
            end
        end
    end

    initial begin
        logic [W-1:0] cur;
        int           timeout;
        reset = 1'b0;
        in    = '0;
        // Reset with inputs high, then release: full qualification with one rise.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'hF);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'hF);
        // Clean steps on channel 0.
        for (int i = 0; i < 4; i++) drive(1'b0, 4'h0);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h1);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h0);
        // Glitches on channel 1: 3 cycles rejected, 4 cycles accepted.
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h2);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h0);
        for (int i = 0; i < 4; i++) drive(1'b1, 4'h2);
        for (int i = 0; i < 12; i++) drive(1'b1, 4'h0);
        // Simultaneous rise and fall on different channels.
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h8);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h4);
        // Reset mid-debounce discards the partial count.
        for (int i = 0; i < 3; i++) drive(1'b0, 4'h0);
        drive(1'b1, 4'h1);
        drive(1'b1, 4'h1);
        drive(1'b1, 4'h1);
        drive(1'b0, 4'h1);
        for (int i = 0; i < 10; i++) drive(1'b1, 4'h1);
        // Randomised: sparse bit flips with occasional resets.
        cur = '0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) == 0) cur = cur ^ W'($urandom_range(15));
            drive(($urandom_range(99) != 0), cur);
        end
        timeout = 0;
        while (exp_q.size() != 0 && timeout < 20) begin
            @(posedge clk);
            timeout++;
        end
        #3;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain at %0t: got %0d pending expected 0", $time, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
